// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_trace_buffer
// Purpose  : Captures one writeback trace event per cycle after a post-reset
//            warm-up period. Event kinds are GPR write, HI/LO write, CP0 write
//            and skip (idle cycle). Events are queued in a first-word-fall-
//            through FIFO, and a valid/ready interface drains that FIFO.
// Ports    : clk, rst (sync, active-high)
//            reg_write_enable/addr/data - GPR writeback
//            hilo_we, hi_i, lo_i        - HI/LO writeback
//            cp0_we, cp0_waddr, cp0_wdata - CP0 writeback
//            out_valid/out_ready        - head-of-FIFO handshake
//            out_kind/index/addr/data0/data1 - head entry fields
//            level    - FIFO occupancy, overflow - sticky drop flag
// Config   : TRACE_SKIP_EN - when defined, skip events are enqueued as well;
//            otherwise they only advance the index.
// Revision : 1.0 - initial release
// ============================================================================
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int WARMUP = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write_enable,
    input  logic [4:0]               reg_write_addr,
    input  logic [31:0]              reg_write_data,
    input  logic                     hilo_we,
    input  logic [31:0]              hi_i,
    input  logic [31:0]              lo_i,
    input  logic                     cp0_we,
    input  logic [4:0]               cp0_waddr,
    input  logic [31:0]              cp0_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [31:0]              out_index,
    output logic [4:0]               out_addr,
    output logic [31:0]              out_data0,
    output logic [31:0]              out_data1,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [1:0]    c_kind_reg  = 2'd0;
    localparam logic [1:0]    c_kind_hilo = 2'd1;
    localparam logic [1:0]    c_kind_cp0  = 2'd2;
    localparam logic [1:0]    c_kind_skip = 2'd3;
    localparam logic [LW-1:0] c_depth     = LW'(DEPTH);
    localparam logic [WW-1:0] c_warmup    = WW'(WARMUP);

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] index;
        logic [4:0]  addr;
        logic [31:0] data0;
        logic [31:0] data1;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [31:0]     r_index;
    logic [WW-1:0]   r_warm_cnt;
    logic            r_overflow;

    entry_t          w_new;
    entry_t          w_head;
    logic            w_event;
    logic            w_enq_req;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Warm-up is over once the counter saturates at WARMUP; every edge after
    // that produces exactly one event.
    assign w_event = (r_warm_cnt == c_warmup);

    // Priority encode: reg > hilo > cp0 > skip. Lower-priority strobes in the
    // same cycle are discarded silently.
    always_comb begin
        w_new       = '0;
        w_new.index = r_index + 32'd1;
        if (reg_write_enable) begin
            w_new.kind  = c_kind_reg;
            w_new.addr  = reg_write_addr;
            w_new.data0 = reg_write_data;
        end else if (hilo_we) begin
            w_new.kind  = c_kind_hilo;
            w_new.data0 = hi_i;
            w_new.data1 = lo_i;
        end else if (cp0_we) begin
            w_new.kind  = c_kind_cp0;
            w_new.addr  = cp0_waddr;
            w_new.data0 = cp0_wdata;
        end else begin
            w_new.kind  = c_kind_skip;
        end
    end

`ifdef TRACE_SKIP_EN
    assign w_enq_req = w_event;
`else
    // Skips still consume an index so the consumer sees gaps for idle cycles.
    assign w_enq_req = w_event && (w_new.kind != c_kind_skip);
`endif

    assign w_full = (r_level == c_depth);
    assign w_pop  = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push = w_enq_req && (!w_full || w_pop);
    assign w_drop = w_enq_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm_cnt <= '0;
            r_index    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (!w_event) begin
                r_warm_cnt <= r_warm_cnt + WW'(1);
            end
            if (w_event) begin
                r_index <= w_new.index;
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observable while level != 0.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= w_new;
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign out_valid = (r_level != '0);
    assign out_kind  = out_valid ? w_head.kind  : 2'd0;
    assign out_index = out_valid ? w_head.index : 32'd0;
    assign out_addr  = out_valid ? w_head.addr  : 5'd0;
    assign out_data0 = out_valid ? w_head.data0 : 32'd0;
    assign out_data1 = out_valid ? w_head.data1 : 32'd0;
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 16, number of FIFO entries; a power of two, at least 2.
- WARMUP, 5, number of post-reset cycles that produce no event.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all logic is on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- reg_write_enable, in, 1, GPR writeback strobe.
- reg_write_addr, in, 5, GPR index.
- reg_write_data, in, 32, GPR data.
- hilo_we, in, 1, HI/LO write strobe.
- hi_i, in, 32, HI value.
- lo_i, in, 32, LO value.
- cp0_we, in, 1, CP0 write strobe.
- cp0_waddr, in, 5, CP0 register index.
- cp0_wdata, in, 32, CP0 data.
- out_valid, out, 1, the head FIFO entry is presentable.
- out_ready, in, 1, the consumer accepts the head entry.
- out_kind, out, 2, event type: 0 = reg, 1 = hilo, 2 = cp0, 3 = skip.
- out_index, out, 32, cycle index of the event, starting at 1.
- out_addr, out, 5, reg_write_addr or cp0_waddr; 0 for hilo and skip.
- out_data0, out, 32, reg_write_data, hi_i or cp0_wdata; 0 for skip.
- out_data1, out, 32, lo_i for hilo; otherwise 0.
- level, out, $clog2(DEPTH)+1, current FIFO occupancy.
- overflow, out, 1, sticky flag: an event was dropped.

Function
REQ-003 Warm-up counter: after rst deasserts, the first WARMUP rising edges SHALL produce no event and SHALL NOT advance the index.
REQ-004 Event generation: after warm-up, every cycle SHALL generate exactly one event.
- The index counter is pre-incremented, so the first event has index 1.
- The index wraps from 0xFFFFFFFF to 0.
REQ-005 Kind priority SHALL be reg > hilo > cp0 > skip. Only the highest-priority strobe asserted in a cycle is recorded; the others are discarded with no flag.
REQ-006 Writes to GPR $0 SHALL be recorded unchanged, with addr = 0 and the data as presented.
REQ-007 The FIFO SHALL be first-word-fall-through.
- out_valid = (level != 0).
- All out_* fields are driven combinationally from the head entry.
- out_* fields are 0 when the FIFO is empty.
REQ-008 Handshake: a pop occurs on a rising edge where out_valid and out_ready are both 1.
- Once out_valid is high, the head entry SHALL remain stable until it is popped.
- out_ready while out_valid is low has no effect.
REQ-009 Push when not full: the event is written and the event is visible on out_* one cycle after capture if the FIFO was empty (latency 1).
REQ-010 Full boundary:
- Push with a simultaneous pop while full SHALL succeed; level stays DEPTH.
- Push without a pop while full SHALL drop the event, set overflow, and still advance the index.
REQ-011 Simultaneous push and pop when not full SHALL leave level unchanged.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH.
REQ-013 overflow SHALL be cleared only by rst.

Reset
REQ-014 While rst is high on a rising edge, the block SHALL clear:
- FIFO pointers and level to 0;
- out_valid to 0;
- overflow to 0;
- the index counter to 0;
- the warm-up counter, which restarts.
REQ-015 Reset asserted mid-stream SHALL discard all buffered entries. No partial entry SHALL survive.
REQ-016 Inputs SHALL be ignored during reset and during warm-up.

Configuration
REQ-017 With macro TRACE_SKIP_EN defined, skip events (kind 3) SHALL be enqueued like any other event.
REQ-018 Without TRACE_SKIP_EN:
- Skip events SHALL NOT be enqueued and SHALL NOT set overflow.
- The index SHALL still advance, so gaps in out_index mark idle cycles.

Verification
REQ-019 Warm-up and first event: release rst, hold reg_write_enable = 1, addr = 3, data = 0x1234 from release onward -> after 5 silent cycles, the first entry is kind 0, index 1, addr 3, data0 0x00001234.
REQ-020 Priority: reg_write_enable, hilo_we and cp0_we all asserted in one cycle, with hi = 0xA and lo = 0xB -> exactly one entry, of kind 0; next cycle hilo alone -> kind 1, data0 0xA, data1 0xB, index +1.
REQ-021 Overflow: DEPTH = 16, out_ready = 0, 17 reg writes -> level 16, overflow 1; draining yields indices 1..16 in order.
REQ-022 Full with concurrent pop: FIFO full, out_ready = 1, writes continue -> level stays 16, no overflow, indices remain contiguous.
REQ-023 Skip handling: 3 idle cycles after warm-up, then a cp0 write to reg 12 with data 0x1 ->
- with TRACE_SKIP_EN: kinds 3, 3, 3, 2 with indices 1..4;
- without: a single kind 2 entry at index 4.
REQ-024 Reset mid-stream: 8 entries buffered, pulse rst for 1 cycle -> level 0, out_valid 0, overflow 0; the next event after warm-up has index 1.
